// File: rtl/ram_pkt_packer_if.sv
// Bus bundle for ram_pkt_packer: burst request, RAM read port, frame output and status.
// The packer connects through the slave modport; its user (and the RAM) through master.
interface ram_pkt_packer_if;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  count;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;

  modport slave (
    input  start, start_addr, count, ram_rd_data, data_ready,
    output ram_rd_en, ram_rd_addr, data_out, data_valid, busy, done
  );

  modport master (
    output start, start_addr, count, ram_rd_data, data_ready,
    input  ram_rd_en, ram_rd_addr, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/ram_pkt_packer.sv
// Reads a burst of 16-bit words from a synchronous RAM and emits one 32-bit frame
// per word as {data, address, nibble checksum, marker} over a valid/ready handshake.
module ram_pkt_packer #(
  parameter logic [3:0] MARKER = 4'hE
) (
  input logic            clk,
  input logic            reset,
  ram_pkt_packer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  addr_q;
  logic [8:0]  remaining;
  logic [31:0] data_out_q;
  logic [3:0]  chk;

  logic rd_en;
  logic valid;
  logic busy_c;
  logic done_c;
  logic load;
  logic capture;
  logic handshake;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    valid      = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          load       = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        rd_en      = 1'b1;
        next_state = CAPT;
      end
      CAPT: begin
        capture    = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        valid = 1'b1;
        if (bus.data_ready) begin
          handshake  = 1'b1;
          // remaining still holds the pre-handshake value here
          next_state = (remaining > 9'd1) ? READ : DONE;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign chk = bus.ram_rd_data[15:12] ^ bus.ram_rd_data[11:8] ^
               bus.ram_rd_data[7:4]   ^ bus.ram_rd_data[3:0]  ^
               addr_q[7:4]            ^ addr_q[3:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= 8'h00;
      remaining  <= 9'd0;
      data_out_q <= 32'h0;
    end else begin
      if (load) begin
        addr_q    <= bus.start_addr;
        remaining <= (bus.count == 8'h00) ? 9'd256 : {1'b0, bus.count};
      end
      if (capture) begin
        data_out_q <= {bus.ram_rd_data, addr_q, chk, MARKER};
      end
      if (handshake) begin
        remaining <= remaining - 9'd1;
        addr_q    <= addr_q + 8'd1;  // wraps FF -> 00 naturally
      end
    end
  end

  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = addr_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = valid;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;

endmodule

// File: tb/tb_ram_pkt_packer.sv
// Self-checking bench for ram_pkt_packer: table-driven bursts against a frame/read
// scoreboard, plus hand-written latency and mid-burst reset sequences.
module tb_ram_pkt_packer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_pkt_packer_if bus ();

  ram_pkt_packer #(.MARKER(4'hE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous RAM: data appears the cycle after the read strobe
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [7:0] a);
    logic [15:0] d;
    logic [3:0]  c;
    d = mem[a];
    c = d[15:12] ^ d[11:8] ^ d[7:4] ^ d[3:0] ^ a[7:4] ^ a[3:0];
    return {d, a, c, 4'hE};
  endfunction

  logic [31:0] exp_frames[$];
  logic [7:0]  exp_reads[$];
  logic [31:0] got[$];

  task automatic push_burst(input logic [7:0] sa, input logic [7:0] cnt);
    int n;
    logic [7:0] a;
    n = (cnt == 8'h00) ? 256 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      a = sa + 8'(i);
      exp_reads.push_back(a);
      exp_frames.push_back(frame_of(a));
    end
  endtask

  // Monitor: samples on the falling edge, between input drives and active edges
  bit          mon_en = 1'b0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  bit          prev_hold = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] last_frame = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
      have_last = 1'b0;
    end else if (mon_en) begin
      if (bus.ram_rd_en) begin
        if (exp_reads.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_read: got addr %h expected no read", bus.ram_rd_addr);
        end else begin
          check("rd_addr", {24'h0, bus.ram_rd_addr}, {24'h0, exp_reads.pop_front()});
        end
      end
      if (bus.data_valid) begin
        if (prev_hold) check("hold_stable", bus.data_out, prev_data);
        last_frame = bus.data_out;
        have_last  = 1'b1;
        if (bus.data_ready) begin
          hs_cnt++;
          got.push_back(bus.data_out);
          if (exp_frames.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_frame: got %h expected no frame", bus.data_out);
          end else begin
            check("frame", bus.data_out, exp_frames.pop_front());
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_data = bus.data_out;
        end
      end else begin
        prev_hold = 1'b0;
        if (have_last) check("idle_hold", bus.data_out, last_frame);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic run_burst(input logic [7:0] sa, input logic [7:0] cnt, input int stall_len,
                           input bit inject, input bit chk_first, input logic [31:0] exp_first);
    int n;
    int hs0;
    int d0;
    int stall;
    bit seen;
    n     = (cnt == 8'h00) ? 256 : int'(cnt);
    hs0   = hs_cnt;
    d0    = done_cnt;
    stall = 0;
    seen  = 1'b0;
    push_burst(sa, cnt);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = sa;
    bus.count      = cnt;
    bus.data_ready = 1'b0;
    for (int cyc = 0; cyc < n * (stall_len + 4) + 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        seen           = 1'b1;
        bus.data_ready = 1'b0;
      end else begin
        if (bus.data_valid) begin
          if (stall >= stall_len) begin
            bus.data_ready = 1'b1;
            stall          = 0;
          end else begin
            bus.data_ready = 1'b0;
            stall++;
          end
        end else begin
          bus.data_ready = 1'($urandom_range(0, 1));
        end
        if (inject && bus.busy && $urandom_range(0, 7) == 0) begin
          bus.start      = 1'b1;
          bus.start_addr = 8'($urandom);
          bus.count      = 8'($urandom);
        end
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done for burst at %h", sa);
    end
    @(negedge clk); #1;
    check("handshakes", 32'(hs_cnt - hs0), 32'(n));
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("frames_left", 32'(exp_frames.size()), 32'd0);
    check("reads_left", 32'(exp_reads.size()), 32'd0);
    if (chk_first && got.size() > hs0) check("first_frame", got[hs0], exp_first);
  endtask

  typedef struct {
    logic [7:0]  sa;
    logic [7:0]  cnt;
    int          stall;
    bit          inject;
    bit          chk_first;
    logic [31:0] first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int d0;
    bit hit;

    for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
    mem[8'h00] = 16'h0000;
    mem[8'h05] = 16'h1234;
    mem[8'hA5] = 16'hFFFF;

    vecs[0] = '{sa: 8'h05, cnt: 8'd1, stall: 0, inject: 1'b0, chk_first: 1'b1, first: 32'h1234051E};
    vecs[1] = '{sa: 8'h10, cnt: 8'd3, stall: 4, inject: 1'b0, chk_first: 1'b1, first: 32'h10EF101E};
    vecs[2] = '{sa: 8'hFE, cnt: 8'd3, stall: 1, inject: 1'b0, chk_first: 1'b1, first: 32'hFE01FE1E};
    vecs[3] = '{sa: 8'h00, cnt: 8'd0, stall: 0, inject: 1'b1, chk_first: 1'b1, first: 32'h0000000E};
    vecs[4] = '{sa: 8'hA5, cnt: 8'd1, stall: 2, inject: 1'b0, chk_first: 1'b1, first: 32'hFFFFA5FE};
    vecs[5] = '{sa: 8'h30, cnt: 8'd2, stall: 2, inject: 1'b0, chk_first: 1'b1, first: 32'h30CF303E};

    bus.start      = 1'b0;
    bus.start_addr = 8'h00;
    bus.count      = 8'h00;
    bus.data_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_valid", {31'h0, bus.data_valid}, 32'h0);
    check("rst_rd_en", {31'h0, bus.ram_rd_en}, 32'h0);
    check("rst_rd_addr", {24'h0, bus.ram_rd_addr}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Cycle-exact single word: start honoured on the first edge after release
    push_burst(8'h05, 8'd1);
    #1;
    bus.start      = 1'b1;
    bus.start_addr = 8'h05;
    bus.count      = 8'd1;
    bus.data_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("lat_rd_en", {31'h0, bus.ram_rd_en}, 32'h1);
    check("lat_rd_addr", {24'h0, bus.ram_rd_addr}, 32'h05);
    check("lat_busy", {31'h0, bus.busy}, 32'h1);
    check("lat_valid_e1", {31'h0, bus.data_valid}, 32'h0);
    @(negedge clk);
    check("lat_rd_en_off", {31'h0, bus.ram_rd_en}, 32'h0);
    check("lat_valid_e2", {31'h0, bus.data_valid}, 32'h0);
    @(negedge clk);
    check("lat_valid_e3", {31'h0, bus.data_valid}, 32'h1);
    check("lat_data", bus.data_out, 32'h1234051E);
    @(negedge clk);
    check("lat_valid_drop", {31'h0, bus.data_valid}, 32'h0);
    check("lat_done", {31'h0, bus.done}, 32'h1);
    check("lat_data_hold", bus.data_out, 32'h1234051E);
    @(negedge clk);
    check("lat_done_off", {31'h0, bus.done}, 32'h0);
    check("lat_busy_off", {31'h0, bus.busy}, 32'h0);
    bus.data_ready = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_burst(vecs[v].sa, vecs[v].cnt, vecs[v].stall, vecs[v].inject,
                vecs[v].chk_first, vecs[v].first);
    end

    // Reset while the second frame of a 4-word burst waits in SEND
    push_burst(8'h20, 8'd4);
    hs0 = hs_cnt;
    d0  = done_cnt;
    hit = 1'b0;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = 8'h20;
    bus.count      = 8'd4;
    bus.data_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (hs_cnt - hs0 == 1 && bus.data_valid) hit = 1'b1;
      else bus.data_ready = (hs_cnt == hs0);
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL mid_reset_reach: got no second frame expected SEND of frame 2");
    end
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_data_out", bus.data_out, 32'h0);
    check("mid_rst_valid", {31'h0, bus.data_valid}, 32'h0);
    check("mid_rst_rd_en", {31'h0, bus.ram_rd_en}, 32'h0);
    check("mid_rst_rd_addr", {24'h0, bus.ram_rd_addr}, 32'h0);
    check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("mid_rst_done", {31'h0, bus.done}, 32'h0);
    mon_en = 1'b0;
    exp_frames.delete();
    exp_reads.delete();
    bus.data_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_done", {31'h0, bus.done}, 32'h0);
    end
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    run_burst(vecs[5].sa, vecs[5].cnt, vecs[5].stall, vecs[5].inject,
              vecs[5].chk_first, vecs[5].first);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_pkt_packer.md
RAM_PKT_PACKER -- requirements
Module: ram_pkt_packer

Interface
REQ-001 Parameter MARKER, default 4'hE, SHALL be the valid-frame marker placed in data_out[3:0].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
REQ-005 start_addr  input  8  first RAM address of the burst.
REQ-006 count  input  8  words in the burst; 8'h00 means 256.
REQ-007 ram_rd_en  output  1  RAM read strobe.
REQ-008 ram_rd_addr  output  8  RAM read address.
REQ-009 ram_rd_data  input  16  RAM read data, valid the cycle after ram_rd_en.
REQ-010 data_out  output  32  packed frame.
REQ-011 data_valid  output  1  data_out holds a frame.
REQ-012 data_ready  input  1  downstream accepts the frame.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last frame is accepted.

Function
REQ-015 Frame format SHALL be data_out = {ram data[15:0], address[7:0], chk[3:0], MARKER}.
REQ-016 chk SHALL be the XOR of the four data nibbles and the two address nibbles.
REQ-017 States SHALL be IDLE, READ, CAPT, SEND and DONE.
REQ-018 IDLE -> READ on start=1: latch start_addr into addr_q and count into remaining, with 0 loaded as 256 in a 9-bit counter.
REQ-019 READ lasts one cycle: ram_rd_en=1 and ram_rd_addr=addr_q; ram_rd_en SHALL be 0 in all other states.
REQ-020 CAPT lasts one cycle: ram_rd_data and addr_q are registered into data_out; the state then moves to SEND.
REQ-021 The first data_valid SHALL rise 3 clock edges after the edge that sampled start.
REQ-022 SEND: data_valid=1, and data_out SHALL stay stable until an edge with data_ready=1.
REQ-023 A handshake is an edge with data_valid=1 and data_ready=1; at that edge remaining decrements and addr_q increments.
REQ-024 After a handshake, the state SHALL go to READ if remaining > 1, otherwise to DONE.
REQ-025 data_valid SHALL drop in the cycle after the handshake.
REQ-026 Back-to-back frames SHALL therefore be spaced 3 cycles apart when data_ready is held high.
REQ-027 addr_q SHALL wrap from 8'hFF to 8'h00 without error or stall.
REQ-028 DONE lasts one cycle with done=1 and busy=1, then the state returns to IDLE.
REQ-029 start asserted while busy=1 SHALL be ignored, with no effect on the burst in progress.
REQ-030 data_ready while data_valid=0 SHALL be ignored.
REQ-031 data_out SHALL hold its last value when data_valid=0.

Reset
REQ-032 While reset=0, the state SHALL be IDLE and all of the following SHALL be 0: data_out, data_valid, ram_rd_en, ram_rd_addr, busy, done, addr_q, remaining.
REQ-033 Assertion of reset mid-burst SHALL abort the burst immediately, with no done pulse.
REQ-034 The first start SHALL be honoured on the first edge after reset deasserts.

Verification
REQ-035 Single word: start_addr=8'h05, count=1, RAM[05]=16'h1234, data_ready=1 -> ram_rd_en one cycle with addr 8'h05; data_out=32'h1234051E valid 3 edges after start; done 1 cycle later.
REQ-036 Burst with backpressure: start_addr=8'h10, count=3, data_ready low for 4 cycles per frame -> three frames for addresses 10,11,12, each held stable until its handshake; exactly 3 handshakes; one done pulse.
REQ-037 Wrap: start_addr=8'hFE, count=3 -> frame addresses FE, FF, 00 with correct chk; no extra reads.
REQ-038 count=0: start_addr=8'h00 -> 256 frames for addresses 00..FF, then done; start pulses injected mid-burst have no effect.
REQ-039 Reset mid-burst: reset=0 during SEND of the 2nd frame of count=4 -> all outputs 0 within the same cycle, no done; a new start after release runs normally.
REQ-040 Checksum: RAM[A5]=16'hFFFF, start_addr=8'hA5 -> data_out=32'hFFFFA5FE (chk=4'hF); also check RAM[00]=16'h0000 at address 8'h00 -> 32'h0000000E.
